// File: rtl/sudoku_cmd_engine_if.sv
// Command and puzzle-ROM bus between the button/ROM side and the Sudoku command engine.
// The master side issues command strobes and returns ROM data; the slave side is the engine.
interface sudoku_cmd_engine_if;
  logic [1:0] puzzle_selector;
  logic       cmd_up;
  logic       cmd_down;
  logic       cmd_left;
  logic       cmd_right;
  logic [3:0] cmd_number;
  logic       cmd_enter;
  logic       cmd_valid;
  logic [1:0] rom_puzzle;
  logic [6:0] rom_addr;
  logic [7:0] rom_data;
  logic       engine_ready;

  modport master (
    output puzzle_selector, cmd_up, cmd_down, cmd_left, cmd_right,
    output cmd_number, cmd_enter, cmd_valid, rom_data,
    input  rom_puzzle, rom_addr, engine_ready
  );

  modport slave (
    input  puzzle_selector, cmd_up, cmd_down, cmd_left, cmd_right,
    input  cmd_number, cmd_enter, cmd_valid, rom_data,
    output rom_puzzle, rom_addr, engine_ready
  );
endinterface

// File: rtl/sudoku_cmd_engine.sv
// Sudoku command engine: owns the play grid, fixed-cell mask, cursor and win/lose
// status; loads puzzles from a registered ROM and re-checks the board after every entry.
//
// state     | meaning
// ----------+-----------------------------------------------------------------
// S_LOAD    | sweep ROM 0..80, copy givens into grid and mask (1 extra cycle latency)
// S_IDLE    | accept cursor moves and number entries
// S_WR_ADDR | present the latched cell index to the ROM
// S_WR_CMP  | write the entry, count a mistake if it disagrees with the solution
// S_CHECK   | sweep ROM 0..80 comparing every cell to its solution, update flags
// S_DONE    | game won or lost; grid and cursor frozen until restart
module sudoku_cmd_engine #(
  parameter int MAX_MISTAKES = 3
) (
  input  logic                   clk,
  input  logic                   reset_n,
  sudoku_cmd_engine_if.slave     bus,
  output logic [3:0]             current_x,
  output logic [3:0]             current_y,
  output logic [3:0]             current_val,
  output logic [0:8][0:8][3:0]   grid_out,
  output logic [0:8][0:8]        fixed_mask_out,
  output logic                   game_won,
  output logic                   game_lost
);

  typedef enum logic [2:0] {
    S_LOAD,
    S_IDLE,
    S_WR_ADDR,
    S_WR_CMP,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [6:0] LAST_CELL = 7'd80;
  // Sweeps run one count past the last cell to absorb the ROM's registered read.
  localparam logic [6:0] SWEEP_END = 7'd81;
  localparam logic [3:0] MAX_M     = 4'(MAX_MISTAKES);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cells [0:80];
  logic       mask  [0:80];
  logic [6:0] cnt;
  logic [6:0] prev_idx;
  logic [1:0] puzzle_q;
  logic [3:0] mistakes;
  logic [6:0] lat_idx;
  logic [3:0] lat_val;
  logic       match_acc;
  logic [6:0] cur_idx;
  logic [3:0] given;
  logic [3:0] solution;
  logic       any_dir;
  logic       puzzle_change;
  logic       restart;
  logic       do_move;
  logic       do_entry;
  logic       won_final;
  logic       lost_final;

  // ROM data returned this cycle belongs to the address issued one cycle earlier.
  assign prev_idx      = cnt - 7'd1;
  assign given         = bus.rom_data[3:0];
  assign solution      = bus.rom_data[7:4];
  assign cur_idx       = 7'(current_y) * 7'd9 + 7'(current_x);
  assign current_val   = cells[cur_idx];
  assign any_dir       = bus.cmd_up | bus.cmd_down | bus.cmd_left | bus.cmd_right;
  assign puzzle_change = (bus.puzzle_selector != puzzle_q);
  assign won_final     = match_acc & (cells[LAST_CELL] == solution);
  assign lost_final    = (mistakes == MAX_M);

  assign bus.engine_ready = (state == S_IDLE);
  // On the first load cycle the selector is forwarded so the very first ROM read
  // (including the one right after reset) already targets the selected puzzle.
  assign bus.rom_puzzle   = (state == S_LOAD && cnt == 7'd0) ? bus.puzzle_selector : puzzle_q;

  // ROM address: sweep counter during load/check, latched cell during an entry.
  always_comb begin
    bus.rom_addr = 7'd0;
    case (state)
      S_LOAD, S_CHECK:     bus.rom_addr = (cnt > LAST_CELL) ? LAST_CELL : cnt;
      S_WR_ADDR, S_WR_CMP: bus.rom_addr = lat_idx;
      default:             bus.rom_addr = 7'd0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_LOAD;
    else          state <= state_nxt;
  end

  // Next-state and command decode; puzzle change outranks any same-cycle command.
  always_comb begin
    state_nxt = state;
    restart   = 1'b0;
    do_move   = 1'b0;
    do_entry  = 1'b0;
    case (state)
      S_LOAD: begin
        if (cnt == SWEEP_END) state_nxt = S_IDLE;
      end
      S_IDLE: begin
        if (puzzle_change) begin
          restart   = 1'b1;
          state_nxt = S_LOAD;
        end else if (bus.cmd_valid) begin
          if (any_dir) begin
            do_move = 1'b1;
          end else if (!mask[cur_idx] && bus.cmd_number <= 4'd9) begin
            do_entry  = 1'b1;
            state_nxt = S_WR_ADDR;
          end
        end
      end
      S_WR_ADDR: state_nxt = S_WR_CMP;
      S_WR_CMP:  state_nxt = S_CHECK;
      S_CHECK: begin
        if (cnt == SWEEP_END) state_nxt = (won_final || lost_final) ? S_DONE : S_IDLE;
      end
      S_DONE: begin
        if (puzzle_change || (bus.cmd_valid && bus.cmd_enter)) begin
          restart   = 1'b1;
          state_nxt = S_LOAD;
        end
      end
      default: state_nxt = S_LOAD;
    endcase
  end

  // Grid, mask, cursor, counters and status flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 81; i++) begin
        cells[i] <= 4'd0;
        mask[i]  <= 1'b0;
      end
      cnt       <= 7'd0;
      puzzle_q  <= 2'd0;
      mistakes  <= 4'd0;
      lat_idx   <= 7'd0;
      lat_val   <= 4'd0;
      match_acc <= 1'b1;
      current_x <= 4'd0;
      current_y <= 4'd0;
      game_won  <= 1'b0;
      game_lost <= 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          if (cnt == 7'd0) begin
            puzzle_q <= bus.puzzle_selector;
          end else begin
            cells[prev_idx] <= given;
            mask[prev_idx]  <= (given != 4'd0);
          end
          cnt <= (cnt == SWEEP_END) ? 7'd0 : cnt + 7'd1;
        end
        S_IDLE, S_DONE: begin
          if (restart) begin
            mistakes  <= 4'd0;
            game_won  <= 1'b0;
            game_lost <= 1'b0;
            current_x <= 4'd0;
            current_y <= 4'd0;
            cnt       <= 7'd0;
            puzzle_q  <= bus.puzzle_selector;
          end else if (do_move) begin
            if (bus.cmd_up)
              current_y <= (current_y == 4'd0) ? 4'd8 : current_y - 4'd1;
            else if (bus.cmd_down)
              current_y <= (current_y == 4'd8) ? 4'd0 : current_y + 4'd1;
            else if (bus.cmd_left)
              current_x <= (current_x == 4'd0) ? 4'd8 : current_x - 4'd1;
            else
              current_x <= (current_x == 4'd8) ? 4'd0 : current_x + 4'd1;
          end else if (do_entry) begin
            lat_idx <= cur_idx;
            lat_val <= bus.cmd_number;
          end
        end
        S_WR_CMP: begin
          cells[lat_idx] <= lat_val;
          if (lat_val != 4'd0 && lat_val != solution && mistakes < MAX_M)
            mistakes <= mistakes + 4'd1;
          cnt       <= 7'd0;
          match_acc <= 1'b1;
        end
        S_CHECK: begin
          if (cnt != 7'd0) match_acc <= match_acc & (cells[prev_idx] == solution);
          if (cnt == SWEEP_END) begin
            cnt <= 7'd0;
            if (won_final)  game_won  <= 1'b1;
            if (lost_final) game_lost <= 1'b1;
          end else begin
            cnt <= cnt + 7'd1;
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar gy = 0; gy < 9; gy++) begin : g_row
    for (genvar gx = 0; gx < 9; gx++) begin : g_col
      assign grid_out[gy][gx]       = cells[gy*9 + gx];
      assign fixed_mask_out[gy][gx] = mask[gy*9 + gx];
    end
  end

endmodule

// File: tb/tb_sudoku_cmd_engine.sv
// Bench for sudoku_cmd_engine: random puzzle ROM, directed scenarios and random
// commands, checked every cycle against a cycle-counting game model.
module tb_sudoku_cmd_engine;
  localparam int MAXM     = 3;
  localparam int PH_LOAD  = 0;
  localparam int PH_IDLE  = 1;
  localparam int PH_ENTRY = 2;
  localparam int PH_DONE  = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  sudoku_cmd_engine_if bus();
  logic [3:0]           current_x, current_y, current_val;
  logic [0:8][0:8][3:0] grid_out;
  logic [0:8][0:8]      fixed_mask_out;
  logic                 game_won, game_lost;

  sudoku_cmd_engine #(.MAX_MISTAKES(MAXM)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus),
    .current_x(current_x), .current_y(current_y), .current_val(current_val),
    .grid_out(grid_out), .fixed_mask_out(fixed_mask_out),
    .game_won(game_won), .game_lost(game_lost)
  );

  logic [7:0] rom_mem [0:3][0:80];
  always @(posedge clk) bus.rom_data <= rom_mem[int'(bus.rom_puzzle)][int'(bus.rom_addr)];

  int tests = 0;
  int fails = 0;

  // Game model
  int m_phase, m_cnt, m_cx, m_cy, m_mist, m_puz, m_idx, m_val;
  bit m_won, m_lost;
  int m_grid [81];
  bit m_mask [81];

  function automatic int gv(int p, int i);
    logic [7:0] b;
    b = rom_mem[p][i];
    return int'(b[3:0]);
  endfunction

  function automatic int sv(int p, int i);
    logic [7:0] b;
    b = rom_mem[p][i];
    return int'(b[7:4]);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_restart();
    m_mist = 0; m_won = 0; m_lost = 0; m_cx = 0; m_cy = 0;
    m_puz = int'(bus.puzzle_selector);
    m_phase = PH_LOAD; m_cnt = 0;
  endtask

  task automatic m_reset();
    for (int i = 0; i < 81; i++) begin m_grid[i] = 0; m_mask[i] = 0; end
    m_restart();
  endtask

  task automatic m_step();
    bit all;
    case (m_phase)
      PH_LOAD: begin
        if (m_cnt == 0) m_puz = int'(bus.puzzle_selector);
        m_cnt++;
        if (m_cnt == 82) begin
          for (int i = 0; i < 81; i++) begin
            m_grid[i] = gv(m_puz, i);
            m_mask[i] = (gv(m_puz, i) != 0);
          end
          m_phase = PH_IDLE;
        end
      end
      PH_IDLE: begin
        if (int'(bus.puzzle_selector) != m_puz) m_restart();
        else if (bus.cmd_valid) begin
          if (bus.cmd_up)         m_cy = (m_cy + 8) % 9;
          else if (bus.cmd_down)  m_cy = (m_cy + 1) % 9;
          else if (bus.cmd_left)  m_cx = (m_cx + 8) % 9;
          else if (bus.cmd_right) m_cx = (m_cx + 1) % 9;
          else if (!m_mask[m_cy*9 + m_cx] && int'(bus.cmd_number) <= 9) begin
            m_idx = m_cy*9 + m_cx;
            m_val = int'(bus.cmd_number);
            m_phase = PH_ENTRY;
            m_cnt = 0;
          end
        end
      end
      PH_ENTRY: begin
        m_cnt++;
        if (m_cnt == 2) begin
          m_grid[m_idx] = m_val;
          if (m_val != 0 && m_val != sv(m_puz, m_idx) && m_mist < MAXM) m_mist++;
        end
        if (m_cnt == 84) begin
          all = 1;
          for (int i = 0; i < 81; i++) if (m_grid[i] != sv(m_puz, i)) all = 0;
          m_won  = all;
          m_lost = (m_mist == MAXM);
          m_phase = (m_won || m_lost) ? PH_DONE : PH_IDLE;
        end
      end
      default: begin
        if (int'(bus.puzzle_selector) != m_puz || (bus.cmd_valid && bus.cmd_enter)) m_restart();
      end
    endcase
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) m_reset();
      else m_step();
    end
  end

  // Compare DUT outputs with the model on every falling edge.
  initial begin
    logic [0:8][0:8][3:0] eg;
    logic [0:8][0:8]      em;
    forever begin
      @(negedge clk);
      chk("engine_ready", int'(bus.engine_ready), int'(reset_n && m_phase == PH_IDLE));
      chk("current_x", int'(current_x), m_cx);
      chk("current_y", int'(current_y), m_cy);
      chk("game_won", int'(game_won), int'(m_won));
      chk("game_lost", int'(game_lost), int'(m_lost));
      if (!reset_n) chk("rom_addr_reset", int'(bus.rom_addr), 0);
      if (reset_n && (m_phase == PH_IDLE || m_phase == PH_DONE))
        chk("rom_puzzle", int'(bus.rom_puzzle), m_puz);
      if (!reset_n || m_phase != PH_LOAD) begin
        for (int y = 0; y < 9; y++)
          for (int x = 0; x < 9; x++) begin
            eg[y][x] = 4'(m_grid[y*9 + x]);
            em[y][x] = m_mask[y*9 + x];
          end
        tests++;
        if (grid_out !== eg) begin
          fails++;
          $display("FAIL grid_out: got %h expected %h", grid_out, eg);
        end
        tests++;
        if (fixed_mask_out !== em) begin
          fails++;
          $display("FAIL fixed_mask_out: got %h expected %h", fixed_mask_out, em);
        end
        chk("current_val", int'(current_val), m_grid[m_cy*9 + m_cx]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cmd();
    bus.cmd_up = 0; bus.cmd_down = 0; bus.cmd_left = 0; bus.cmd_right = 0;
    bus.cmd_number = 4'd0; bus.cmd_enter = 0; bus.cmd_valid = 0;
  endtask

  task automatic send(input bit up, input bit dn, input bit lf, input bit rt,
                      input int num, input bit ent, input bit vld);
    bus.cmd_up = up; bus.cmd_down = dn; bus.cmd_left = lf; bus.cmd_right = rt;
    bus.cmd_number = 4'(num); bus.cmd_enter = ent; bus.cmd_valid = vld;
    tick();
    clear_cmd();
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!bus.engine_ready && n < 400) begin tick(); n++; end
    chk("ready_timeout", int'(bus.engine_ready), 1);
  endtask

  task automatic wait_flag(input bit lost, output int n);
    n = 0;
    while (!(lost ? game_lost : game_won) && n < 400) begin tick(); n++; end
  endtask

  task automatic goto(input int x, input int y);
    int g;
    g = 0;
    while (m_cx != x && g < 20) begin send(0, 0, 0, 1, 0, 0, 1); g++; end
    while (m_cy != y && g < 40) begin send(0, 1, 0, 0, 0, 0, 1); g++; end
  endtask

  task automatic random_step();
    int kind, n, idx;
    repeat ($urandom_range(0, 2)) tick();
    if ($urandom_range(0, 99) < 2) bus.puzzle_selector = 2'($urandom_range(0, 3));
    if (!bus.engine_ready && $urandom_range(0, 3) != 0) begin
      n = 0;
      while (!bus.engine_ready && m_phase != PH_DONE && n < 400) begin tick(); n++; end
    end
    kind = $urandom_range(0, 9);
    idx = m_cy*9 + m_cx;
    if (kind <= 3) begin
      logic [3:0] d;
      d = 4'($urandom_range(1, 15));
      send(d[3], d[2], d[1], d[0], $urandom_range(0, 15), 0, 1);
    end else if (kind <= 6) send(0, 0, 0, 0, sv(m_puz, idx), 0, 1);
    else if (kind == 7)     send(0, 0, 0, 0, $urandom_range(0, 15), 0, 1);
    else if (kind == 8)     send(0, 0, 0, 0, $urandom_range(0, 15), 1, 1);
    else begin
      logic [3:0] d;
      d = 4'($urandom_range(0, 15));
      send(d[3], d[2], d[1], d[0], $urandom_range(0, 15), 1, 0);
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, s, g, last, lx, ly;
    int empties [$];
    clear_cmd();
    bus.puzzle_selector = 2'd0;
    for (int p = 0; p < 4; p++)
      for (int i = 0; i < 81; i++) begin
        s = $urandom_range(1, 9);
        g = ($urandom_range(0, 99) < 45) ? s : 0;
        rom_mem[p][i] = {4'(s), 4'(g)};
      end
    rom_mem[0][0] = {4'd5, 4'd5};
    for (int p = 0; p < 4; p++) rom_mem[p][1] = {4'd7, 4'd0};

    // Reset and initial load of puzzle 0
    repeat (3) tick();
    reset_n = 1;
    wait_ready(n);
    chk("load_latency", n, 82);
    chk("cell00_val", int'(grid_out[0][0]), 5);
    chk("cell00_fixed", int'(fixed_mask_out[0][0]), 1);
    chk("cell01_val", int'(grid_out[0][1]), 0);
    chk("cell01_fixed", int'(fixed_mask_out[0][1]), 0);
    chk("start_x", int'(current_x), 0);

    // Cursor moves with wrap and priority
    send(1, 0, 0, 0, 0, 0, 1);
    chk("up_wrap_y", int'(current_y), 8);
    send(0, 0, 1, 0, 0, 0, 1);
    chk("left_wrap_x", int'(current_x), 8);
    send(1, 0, 0, 1, 0, 0, 1);
    chk("up_over_right_y", int'(current_y), 7);
    chk("up_over_right_x", int'(current_x), 8);

    // Entries on a fixed cell and out-of-range values are ignored
    goto(0, 0);
    send(0, 0, 0, 0, 3, 0, 1);
    chk("fixed_ready", int'(bus.engine_ready), 1);
    chk("fixed_keep", int'(grid_out[0][0]), 5);
    goto(1, 0);
    send(0, 0, 0, 0, 12, 0, 1);
    chk("gt9_ready", int'(bus.engine_ready), 1);
    chk("gt9_keep", int'(grid_out[0][1]), 0);

    // Wrong entry then clear
    send(0, 0, 0, 0, 4, 0, 1);
    chk("entry_busy", int'(bus.engine_ready), 0);
    wait_ready(n);
    chk("entry_latency", n, 84);
    chk("wrong_shown", int'(grid_out[0][1]), 4);
    send(0, 0, 0, 0, 0, 0, 1);
    wait_ready(n);
    chk("cleared", int'(grid_out[0][1]), 0);
    chk("not_lost", int'(game_lost), 0);

    // Fill every empty cell with its solution
    for (int i = 0; i < 81; i++) if (gv(0, i) == 0) empties.push_back(i);
    last = empties[empties.size() - 1];
    lx = last % 9; ly = last / 9;
    for (int k = 0; k < empties.size() - 1; k++) begin
      goto(empties[k] % 9, empties[k] / 9);
      send(0, 0, 0, 0, sv(0, empties[k]), 0, 1);
      wait_ready(n);
    end
    goto(lx, ly);
    send(0, 0, 0, 0, sv(0, last), 0, 1);
    wait_flag(0, n);
    chk("win_latency", n, 84);
    chk("won", int'(game_won), 1);
    tick();
    chk("done_not_ready", int'(bus.engine_ready), 0);
    send(0, 0, 0, 1, 0, 0, 1);
    chk("done_frozen_x", int'(current_x), lx);
    send(0, 0, 0, 0, 0, 1, 1);
    wait_ready(n);
    chk("restart_latency", n, 82);
    chk("restart_won", int'(game_won), 0);

    // Three wrong entries lose the game
    goto(1, 0);
    send(0, 0, 0, 0, 4, 0, 1); wait_ready(n);
    send(0, 0, 0, 0, 4, 0, 1); wait_ready(n);
    chk("two_wrong_not_lost", int'(game_lost), 0);
    send(0, 0, 0, 0, 4, 0, 1);
    wait_flag(1, n);
    chk("lose_latency", n, 84);
    chk("lost", int'(game_lost), 1);
    send(1, 0, 0, 0, 0, 0, 1);
    chk("lost_frozen_y", int'(current_y), 0);
    send(0, 0, 0, 0, 0, 1, 1);
    wait_ready(n);
    chk("lost_cleared", int'(game_lost), 0);

    // Puzzle change from IDLE
    bus.puzzle_selector = 2'd2;
    tick();
    wait_ready(n);
    chk("change_latency", n, 82);
    chk("change_rom_puzzle", int'(bus.rom_puzzle), 2);
    chk("change_cell01", int'(grid_out[0][1]), 0);

    // Reset in the middle of the board check
    goto(1, 0);
    send(0, 0, 0, 0, 1, 0, 1);
    repeat (40) tick();
    reset_n = 0;
    #1;
    chk("rst_ready", int'(bus.engine_ready), 0);
    chk("rst_grid_zero", int'(grid_out == '0), 1);
    chk("rst_x", int'(current_x), 0);
    tick(); tick();
    reset_n = 1;
    wait_ready(n);
    chk("rst_reload_latency", n, 82);
    chk("rst_rom_puzzle", int'(bus.rom_puzzle), 2);

    // Random commands
    for (int k = 0; k < 400; k++) random_step();
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
